br_fetch_ctrl: RTL and testbench

- Fetch-stage next-PC sequencer for the 16-bit, 4-bit-opcode ISA.
- Owns the PC register and consumes the branch target produced by the branch-target adder.
- Predicts each branch, tracks one outstanding branch until EX resolves it, and issues redirect and flush on a mispredict.
- Also handles halt and raises a watchdog error if a branch is never resolved.

---
 rtl/br_fetch_ctrl.sv | 148 ++++++++++++++
 tb/tb_br_fetch_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/br_fetch_ctrl.sv
// Fetch-stage next-PC sequencer: PC register, branch prediction, single outstanding branch, redirect/flush, halt, watchdog.
// Optional backward-taken/forward-not-taken prediction is enabled by defining BTFN_PRED_EN.
module br_fetch_ctrl #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [3:0]  BR_OP    = 4'b1100,
    parameter logic [3:0]  HLT_OP   = 4'b0000,
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] instr_if,
    input  logic [15:0] br_pc_if,
    input  logic        stall,
    input  logic        br_res_vld,
    input  logic        br_res_taken,
    output logic [15:0] pc,
    output logic        flush,
    output logic        br_pend,
    output logic        halted,
    output logic        err_timeout
);

    localparam int unsigned PC_W  = 16;
    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

    typedef enum logic [1:0] {RUN, BR_WAIT, HALT} state_t;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [PC_W-1:0]   tgt_q, tgt_d;
    logic [PC_W-1:0]   fall_q, fall_d;
    logic              pred_q, pred_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              flush_q, flush_d;
    logic              br_pend_q, br_pend_d;
    logic              halted_q, halted_d;

    logic [3:0]        opcode_c;
    logic [PC_W-1:0]   pc_inc_c;
    logic              pred_c;
    logic              run_fetch_c;
    logic              unused_ok_c;

    assign opcode_c = instr_if[15:12];
    assign pc_inc_c = pc_q + PC_W'(1);

`ifdef BTFN_PRED_EN
    assign pred_c = instr_if[8];
`else
    assign pred_c = 1'b0;
`endif

    // Low instruction bits only matter to the branch-target adder upstream.
    assign unused_ok_c = ^instr_if[11:0];

    // Next-state, next-PC and output decode
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        tgt_d       = tgt_q;
        fall_d      = fall_q;
        pred_d      = pred_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        flush_d     = 1'b0;
        run_fetch_c = 1'b0;

        case (state_q)
            RUN: run_fetch_c = 1'b1;
            BR_WAIT: begin
                if (br_res_vld) begin
                    state_d = RUN;
                    if (br_res_taken == pred_q) begin
                        run_fetch_c = 1'b1;
                    end else begin
                        pc_d    = br_res_taken ? tgt_q : fall_q;
                        flush_d = 1'b1;
                    end
                end else begin
                    if (cnt_q >= CNT_MAX - CNT_W'(1)) begin
                        cnt_d = CNT_MAX;
                        err_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    // A second branch or a halt waits until the first branch resolves.
                    if (!stall && opcode_c != BR_OP && opcode_c != HLT_OP) begin
                        pc_d = pc_inc_c;
                    end
                end
            end
            default: ;
        endcase

        if (run_fetch_c && !stall) begin
            if (opcode_c == HLT_OP) begin
                state_d = HALT;
            end else if (opcode_c == BR_OP) begin
                tgt_d   = br_pc_if;
                fall_d  = pc_inc_c;
                pred_d  = pred_c;
                pc_d    = pred_c ? br_pc_if : pc_inc_c;
                cnt_d   = '0;
                state_d = BR_WAIT;
            end else begin
                pc_d = pc_inc_c;
            end
        end

        br_pend_d = (state_d == BR_WAIT);
        halted_d  = (state_d == HALT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RUN;
            pc_q      <= RESET_PC;
            tgt_q     <= '0;
            fall_q    <= '0;
            pred_q    <= 1'b0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            flush_q   <= 1'b0;
            br_pend_q <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            tgt_q     <= tgt_d;
            fall_q    <= fall_d;
            pred_q    <= pred_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            flush_q   <= flush_d;
            br_pend_q <= br_pend_d;
            halted_q  <= halted_d;
        end
    end

    assign pc          = pc_q;
    assign flush       = flush_q;
    assign br_pend     = br_pend_q;
    assign halted      = halted_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_br_fetch_ctrl.sv
// Scoreboard bench for br_fetch_ctrl; expectations follow BTFN_PRED_EN when it is defined.
module tb_br_fetch_ctrl;

    localparam logic [15:0] NOP = 16'h1000;
    localparam logic [15:0] BR  = 16'hC000;  // instr[8]=0
    localparam logic [15:0] BRN = 16'hC100;  // instr[8]=1
    localparam logic [15:0] HLT = 16'h0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] instr_if = NOP;
    logic [15:0] br_pc_if = 16'h0000;
    logic        stall = 1'b0;
    logic        br_res_vld = 1'b0;
    logic        br_res_taken = 1'b0;
    logic [15:0] pc;
    logic        flush, br_pend, halted, err_timeout;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [19:0] exp_q[$];
    logic [19:0] obs_q[$];

    br_fetch_ctrl dut (
        .clk(clk), .rst_n(rst_n), .instr_if(instr_if), .br_pc_if(br_pc_if),
        .stall(stall), .br_res_vld(br_res_vld), .br_res_taken(br_res_taken),
        .pc(pc), .flush(flush), .br_pend(br_pend), .halted(halted),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [19:0] ev(input logic [15:0] p, input logic f,
                                       input logic bp, input logic h, input logic e);
        return {p, f, bp, h, e};
    endfunction

    // Drive one cycle of stimulus, queue its expectation, capture the DUT response.
    task automatic step(input logic [15:0] ins, input logic [15:0] bpc, input logic stl,
                        input logic vld, input logic tkn, input logic [19:0] e);
        instr_if = ins; br_pc_if = bpc; stall = stl; br_res_vld = vld; br_res_taken = tkn;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        obs_q.push_back({pc, flush, br_pend, halted, err_timeout});
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        instr_if = NOP; stall = 1'b0; br_res_vld = 1'b0; br_res_taken = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [19:0] o;
        rst_n = 1'b0;
        #2;
        o = {pc, flush, br_pend, halted, err_timeout};
        n_cmp++;
        if (o !== ev(16'h0000, 0, 0, 0, 0)) begin
            n_fail++;
            $display("FAIL reset_async: got %h need %h", o, ev(16'h0000, 0, 0, 0, 0));
        end
        @(posedge clk); #1;
        o = {pc, flush, br_pend, halted, err_timeout};
        n_cmp++;
        if (o !== ev(16'h0000, 0, 0, 0, 0)) begin
            n_fail++;
            $display("FAIL reset_held: got %h need %h", o, ev(16'h0000, 0, 0, 0, 0));
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_sequential();
        logic [19:0] e, o;
        int k = 0;
        step(NOP, 16'h0, 0, 0, 0, ev(16'h0001, 0, 0, 0, 0));
        step(NOP, 16'h0, 0, 0, 0, ev(16'h0002, 0, 0, 0, 0));
        step(NOP, 16'h0, 0, 1, 1, ev(16'h0003, 0, 0, 0, 0));  // resolve ignored in RUN
        step(NOP, 16'h0, 1, 0, 0, ev(16'h0003, 0, 0, 0, 0));  // stall holds
        step(BR,  16'h9, 1, 0, 0, ev(16'h0003, 0, 0, 0, 0));  // stalled branch ignored
        for (int i = 4; i <= 16; i++) step(NOP, 16'h0, 0, 0, 0, ev(16'(i), 0, 0, 0, 0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if (o !== e) begin n_fail++; $display("FAIL sequential[%0d]: got %h need %h", k, o, e); end
            k++;
        end
    endtask

    task automatic test_mispredict_taken();
        logic [19:0] e, o;
        int k = 0;
        step(BR,  16'h0020, 0, 0, 0, ev(16'h0011, 0, 1, 0, 0));
        step(NOP, 16'h0000, 0, 1, 1, ev(16'h0020, 1, 0, 0, 0));
        step(NOP, 16'h0000, 0, 0, 0, ev(16'h0021, 0, 0, 0, 0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if (o !== e) begin n_fail++; $display("FAIL mispredict_taken[%0d]: got %h need %h", k, o, e); end
            k++;
        end
    endtask

    task automatic test_correct_nt();
        logic [19:0] e, o;
        int k = 0;
        step(BR,  16'h0050, 0, 0, 0, ev(16'h0022, 0, 1, 0, 0));
        step(NOP, 16'h0000, 0, 0, 0, ev(16'h0023, 0, 1, 0, 0));
        step(NOP, 16'h0000, 0, 1, 0, ev(16'h0024, 0, 0, 0, 0));
        step(NOP, 16'h0000, 0, 0, 0, ev(16'h0025, 0, 0, 0, 0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if (o !== e) begin n_fail++; $display("FAIL correct_nt[%0d]: got %h need %h", k, o, e); end
            k++;
        end
    endtask

    task automatic test_btfn();
        logic [19:0] e, o;
        int k = 0;
`ifdef BTFN_PRED_EN
        step(BRN, 16'h0015, 0, 0, 0, ev(16'h0015, 0, 1, 0, 0));
        step(NOP, 16'h0000, 0, 1, 0, ev(16'h0026, 1, 0, 0, 0));
        step(NOP, 16'h0000, 0, 0, 0, ev(16'h0027, 0, 0, 0, 0));
`else
        step(BRN, 16'h0015, 0, 0, 0, ev(16'h0026, 0, 1, 0, 0));
        step(NOP, 16'h0000, 0, 1, 0, ev(16'h0027, 0, 0, 0, 0));
        step(NOP, 16'h0000, 0, 0, 0, ev(16'h0028, 0, 0, 0, 0));
`endif
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if (o !== e) begin n_fail++; $display("FAIL btfn[%0d]: got %h need %h", k, o, e); end
            k++;
        end
    endtask

    task automatic test_back_to_back();
        logic [19:0] e, o;
        int k = 0;
        apply_reset();
        step(BR,  16'h0040, 0, 0, 0, ev(16'h0001, 0, 1, 0, 0));
        step(BR,  16'h0060, 0, 1, 0, ev(16'h0002, 0, 1, 0, 0));  // resolve + new branch
        step(NOP, 16'h0000, 0, 1, 1, ev(16'h0060, 1, 0, 0, 0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if (o !== e) begin n_fail++; $display("FAIL back_to_back[%0d]: got %h need %h", k, o, e); end
            k++;
        end
    endtask

    task automatic test_timeout();
        logic [19:0] e, o;
        int k = 0;
        apply_reset();
        step(BR,  16'h0100, 0, 0, 0, ev(16'h0001, 0, 1, 0, 0));
        step(NOP, 16'h0000, 0, 0, 0, ev(16'h0002, 0, 1, 0, 0));  // wait 1
        step(BR,  16'h0300, 0, 0, 0, ev(16'h0002, 0, 1, 0, 0));  // wait 2: second branch holds
        step(NOP, 16'h0000, 1, 0, 0, ev(16'h0002, 0, 1, 0, 0));  // wait 3: stall
        step(HLT, 16'h0000, 0, 0, 0, ev(16'h0002, 0, 1, 0, 0));  // wait 4: no speculative halt
        step(NOP, 16'h0000, 0, 0, 0, ev(16'h0003, 0, 1, 0, 0));  // wait 5
        step(NOP, 16'h0000, 0, 0, 0, ev(16'h0004, 0, 1, 0, 0));  // wait 6
        step(NOP, 16'h0000, 0, 0, 0, ev(16'h0005, 0, 1, 0, 0));  // wait 7
        step(NOP, 16'h0000, 0, 0, 0, ev(16'h0006, 0, 1, 0, 1));  // wait 8: watchdog fires
        step(NOP, 16'h0000, 0, 0, 0, ev(16'h0007, 0, 1, 0, 1));
        step(NOP, 16'h0000, 0, 0, 0, ev(16'h0008, 0, 1, 0, 1));
        step(NOP, 16'h0000, 0, 1, 1, ev(16'h0100, 1, 0, 0, 1));  // late resolve still redirects
        step(BR,  16'h0200, 0, 0, 0, ev(16'h0101, 0, 1, 0, 1));
        step(NOP, 16'h0000, 0, 0, 0, ev(16'h0102, 0, 1, 0, 1));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if (o !== e) begin n_fail++; $display("FAIL timeout[%0d]: got %h need %h", k, o, e); end
            k++;
        end
        #2;
        rst_n = 1'b0;
        #1;
        o = {pc, flush, br_pend, halted, err_timeout};
        n_cmp++;
        if (o !== ev(16'h0000, 0, 0, 0, 0)) begin
            n_fail++;
            $display("FAIL reset_mid_wait: got %h need %h", o, ev(16'h0000, 0, 0, 0, 0));
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_wrap_halt();
        logic [19:0] e, o;
        int k = 0;
        apply_reset();
        step(BR,  16'hFFFF, 0, 0, 0, ev(16'h0001, 0, 1, 0, 0));
        step(NOP, 16'h0000, 0, 1, 1, ev(16'hFFFF, 1, 0, 0, 0));
        step(NOP, 16'h0000, 0, 0, 0, ev(16'h0000, 0, 0, 0, 0));  // wraps
        step(HLT, 16'h0000, 0, 0, 0, ev(16'h0000, 0, 0, 1, 0));
        for (int i = 0; i < 10; i++)
            step(16'($urandom), 16'($urandom), 1'($urandom), 1'(i), 1'($urandom),
                 ev(16'h0000, 0, 0, 1, 0));
        step(BR,  16'h1234, 0, 0, 0, ev(16'h0000, 0, 0, 1, 0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if (o !== e) begin n_fail++; $display("FAIL wrap_halt[%0d]: got %h need %h", k, o, e); end
            k++;
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL sim_timeout: got running need finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        test_reset();
        test_sequential();
        test_mispredict_taken();
        test_correct_nt();
        test_btfn();
        test_back_to_back();
        test_timeout();
        test_wrap_halt();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
